fpu_horner_engine: RTL and testbench

FPU_HORNER_ENGINE -- requirements
Module: fpu_horner_engine

---
 rtl/fpu_horner_pkg.sv | 30 +++
 rtl/fpu_horner_timeout.sv | 36 +++
 rtl/fpu_horner_engine.sv | 236 +++++++++++++++++++++++
 tb/tb_fpu_horner_engine.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_horner_pkg.sv
// Shared definitions for the Horner polynomial engine: FSM state encoding,
// arithmetic-unit flag bit positions and extended-precision FP constants.
package fpu_horner_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FETCH    = 3'd1,
    S_MUL      = 3'd2,
    S_WAIT_MUL = 3'd3,
    S_ADD      = 3'd4,
    S_WAIT_ADD = 3'd5,
    S_DONE     = 3'd6
  } state_t;

  // Bit positions within the 4-bit {inexact, underflow, overflow, invalid} flags
  localparam int unsigned FLAG_INVALID   = 0;
  localparam int unsigned FLAG_OVERFLOW  = 1;
  localparam int unsigned FLAG_UNDERFLOW = 2;
  localparam int unsigned FLAG_INEXACT   = 3;

  // x87 80-bit extended constants
  localparam logic [79:0] FP_ZERO = 80'h0000_0000_0000_0000_0000;
  localparam logic [79:0] FP_ONE  = 80'h3FFF_8000_0000_0000_0000;

  // Invalid or overflow from either unit marks the evaluation as erroneous
  function automatic logic flags_raise_error(input logic [3:0] f);
    return f[FLAG_INVALID] | f[FLAG_OVERFLOW];
  endfunction

endpackage

// File: rtl/fpu_horner_timeout.sv
// Wait-cycle counter for the arithmetic-unit handshakes. Counts while
// count_en is high, clears whenever it is low; expired flags the cycle in
// which the TIMEOUT-th consecutive wait cycle is being spent.
module fpu_horner_timeout #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic count_en,
  output logic expired
);

  localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  logic [CW-1:0] count_q, count_d;

  // Next count: increment while waiting, otherwise return to zero
  always_comb begin
    count_d = '0;
    if (count_en) begin
      count_d = count_q + CW'(1);
    end
  end

  // Counter register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = count_en && (count_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/fpu_horner_engine.sv
// Horner-scheme polynomial evaluator driving external FP multiply/add units
// and a combinational coefficient ROM.
// Optional feature: define FPU_HORNER_ZERO_SHORTCUT_EN to return c0 directly
// when x is +/-0 without issuing any arithmetic.
module fpu_horner_engine
  import fpu_horner_pkg::*;
#(
  parameter int unsigned WIDTH      = 80,
  parameter int unsigned DEG_W      = 4,
  parameter int unsigned SEL_W      = 4,
  parameter int unsigned MAX_DEGREE = 15,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [SEL_W-1:0] poly_select,
  input  logic [DEG_W-1:0] degree,
  input  logic [WIDTH-1:0] x_in,
  output logic [SEL_W-1:0] coeff_poly,
  output logic [DEG_W-1:0] coeff_index,
  input  logic [WIDTH-1:0] coeff_data,
  output logic             mul_enable,
  output logic [WIDTH-1:0] mul_operand_a,
  output logic [WIDTH-1:0] mul_operand_b,
  input  logic [WIDTH-1:0] mul_result,
  input  logic             mul_done,
  input  logic [3:0]       mul_flags,
  output logic             add_enable,
  output logic [WIDTH-1:0] add_operand_a,
  output logic [WIDTH-1:0] add_operand_b,
  input  logic [WIDTH-1:0] add_result,
  input  logic             add_done,
  input  logic [3:0]       add_flags,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_out,
  output logic             error,
  output logic [3:0]       status_flags
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] x_q, x_d, acc_q, acc_d, coef_q, coef_d, res_q, res_d;
  logic [SEL_W-1:0] poly_q, poly_d;
  logic [DEG_W-1:0] idx_q, idx_d;
  logic             first_q, first_d, bad_q, bad_d;
  logic             done_q, done_d, err_q, err_d, busy_q, busy_d;
  logic             mul_en_q, mul_en_d, add_en_q, add_en_d;
  logic [3:0]       stat_q, stat_d;
  logic             waiting, wait_expired;

  assign waiting = (state_q == S_WAIT_MUL) || (state_q == S_WAIT_ADD);

  fpu_horner_timeout #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .count_en(waiting),
    .expired (wait_expired)
  );

  // Next-state, datapath and registered-output computation
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    poly_d  = poly_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    coef_d  = coef_q;
    first_d = first_q;
    bad_d   = bad_q;
    done_d  = done_q;
    err_d   = err_q;
    res_d   = res_q;
    stat_d  = stat_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          x_d     = x_in;
          poly_d  = poly_select;
          idx_d   = degree;
          first_d = 1'b1;
          bad_d   = (32'(degree) > MAX_DEGREE);
          err_d   = 1'b0;
          stat_d  = '0;
          done_d  = 1'b0;
`ifdef FPU_HORNER_ZERO_SHORTCUT_EN
          if (x_in[WIDTH-2:0] == '0) begin
            idx_d = '0;
          end
`endif
          state_d = S_FETCH;
        end
      end

      // A bad degree still passes through FETCH so done lands one edge after start
      S_FETCH: begin
        if (bad_q) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          err_d   = 1'b1;
          res_d   = WIDTH'(FP_ZERO);
        end else if (first_q) begin
          acc_d   = coeff_data;
          first_d = 1'b0;
          if (idx_q == '0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            res_d   = coeff_data;
          end else begin
            state_d = S_MUL;
          end
        end else begin
          coef_d  = coeff_data;
          state_d = S_ADD;
        end
      end

      S_MUL: state_d = S_WAIT_MUL;

      S_WAIT_MUL: begin
        if (mul_done) begin
          acc_d   = mul_result;
          stat_d  = stat_q | mul_flags;
          err_d   = err_q | flags_raise_error(mul_flags);
          idx_d   = idx_q - DEG_W'(1);
          state_d = S_FETCH;
        end else if (wait_expired) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          err_d   = 1'b1;
          res_d   = WIDTH'(FP_ZERO);
        end
      end

      S_ADD: state_d = S_WAIT_ADD;

      S_WAIT_ADD: begin
        if (add_done) begin
          acc_d  = add_result;
          stat_d = stat_q | add_flags;
          err_d  = err_q | flags_raise_error(add_flags);
          if (idx_q == '0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            res_d   = add_result;
          end else begin
            state_d = S_MUL;
          end
        end else if (wait_expired) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          err_d   = 1'b1;
          res_d   = WIDTH'(FP_ZERO);
        end
      end

      S_DONE: begin
        if (!start) begin
          state_d = S_IDLE;
          done_d  = 1'b0;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Abort overrides any completion or timeout decided above
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      done_d  = 1'b0;
      err_d   = err_q;
      res_d   = res_q;
      stat_d  = stat_q;
    end

    busy_d   = (state_d != S_IDLE);
    mul_en_d = (state_d == S_MUL);
    add_en_d = (state_d == S_ADD);
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      x_q      <= '0;
      poly_q   <= '0;
      idx_q    <= '0;
      acc_q    <= '0;
      coef_q   <= '0;
      first_q  <= 1'b0;
      bad_q    <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      res_q    <= '0;
      stat_q   <= '0;
      busy_q   <= 1'b0;
      mul_en_q <= 1'b0;
      add_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      poly_q   <= poly_d;
      idx_q    <= idx_d;
      acc_q    <= acc_d;
      coef_q   <= coef_d;
      first_q  <= first_d;
      bad_q    <= bad_d;
      done_q   <= done_d;
      err_q    <= err_d;
      res_q    <= res_d;
      stat_q   <= stat_d;
      busy_q   <= busy_d;
      mul_en_q <= mul_en_d;
      add_en_q <= add_en_d;
    end
  end

  assign coeff_poly    = poly_q;
  assign coeff_index   = idx_q;
  assign mul_enable    = mul_en_q;
  assign mul_operand_a = acc_q;
  assign mul_operand_b = x_q;
  assign add_enable    = add_en_q;
  assign add_operand_a = acc_q;
  assign add_operand_b = coef_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign result_out    = res_q;
  assign error         = err_q;
  assign status_flags  = stat_q;

endmodule

// File: tb/tb_fpu_horner_engine.sv
// Self-checking bench for fpu_horner_engine. FP multiply/add stubs and the
// reference Horner model work on real-valued conversions of the 80-bit
// operands; coefficients and arguments are small integers/halves so every
// intermediate is exact.
module tb_fpu_horner_engine;
  import fpu_horner_pkg::*;

  localparam int unsigned W    = 80;
  localparam int unsigned DW   = 4;
  localparam int unsigned SW   = 4;
  localparam int unsigned MAXD = 6;
  localparam int unsigned TMO  = 20;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [SW-1:0] poly_select = '0;
  logic [DW-1:0] degree = '0;
  logic [W-1:0]  x_in = '0;
  logic [SW-1:0] coeff_poly;
  logic [DW-1:0] coeff_index;
  logic [W-1:0]  coeff_data;
  logic          mul_enable, mul_done, add_enable, add_done;
  logic [W-1:0]  mul_operand_a, mul_operand_b, mul_result;
  logic [W-1:0]  add_operand_a, add_operand_b, add_result;
  logic [3:0]    mul_flags, add_flags;
  logic          busy, done, error;
  logic [W-1:0]  result_out;
  logic [3:0]    status_flags;

  always #5 clk = ~clk;

  fpu_horner_engine #(
    .WIDTH(W), .DEG_W(DW), .SEL_W(SW), .MAX_DEGREE(MAXD), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .poly_select(poly_select), .degree(degree), .x_in(x_in),
    .coeff_poly(coeff_poly), .coeff_index(coeff_index), .coeff_data(coeff_data),
    .mul_enable(mul_enable), .mul_operand_a(mul_operand_a), .mul_operand_b(mul_operand_b),
    .mul_result(mul_result), .mul_done(mul_done), .mul_flags(mul_flags),
    .add_enable(add_enable), .add_operand_a(add_operand_a), .add_operand_b(add_operand_b),
    .add_result(add_result), .add_done(add_done), .add_flags(add_flags),
    .busy(busy), .done(done), .result_out(result_out), .error(error),
    .status_flags(status_flags)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- x87 extended <-> real conversion ----------------
  function automatic real x2r(input logic [79:0] v);
    real r;
    int  e;
    if (v[78:0] == '0) return 0.0;
    r = real'(longint'({32'd0, v[63:32]})) * 4294967296.0 + real'(longint'({32'd0, v[31:0]}));
    e = int'(v[78:64]) - 16383 - 63;
    while (e > 0) begin r = r * 2.0; e--; end
    while (e < 0) begin r = r / 2.0; e++; end
    return v[79] ? -r : r;
  endfunction

  function automatic logic [79:0] r2x(input real r);
    logic [79:0] v;
    real a;
    int  e;
    v = '0;
    if (r == 0.0) return v;
    a = (r < 0.0) ? -r : r;
    e = 16383;
    while (a >= 2.0) begin a = a / 2.0; e++; end
    while (a < 1.0) begin a = a * 2.0; e--; end
    v[79]    = (r < 0.0);
    v[78:64] = 15'(e);
    for (int i = 63; i >= 0; i--) begin
      if (a >= 1.0) begin v[i] = 1'b1; a = a - 1.0; end
      a = a * 2.0;
    end
    return v;
  endfunction

  function automatic logic [79:0] fmul(input logic [79:0] a, input logic [79:0] b);
    return r2x(x2r(a) * x2r(b));
  endfunction

  function automatic logic [79:0] fadd(input logic [79:0] a, input logic [79:0] b);
    return r2x(x2r(a) + x2r(b));
  endfunction

  // ---------------- coefficient ROM ----------------
  logic [79:0] rom [16][16];
  assign coeff_data = rom[coeff_poly][coeff_index];

  // ---------------- arithmetic unit stubs ----------------
  int          m_lat = 1, a_lat = 1;
  bit          m_hang = 1'b0;
  int          m_cnt = 0, a_cnt = 0;
  int          m_pulses = 0, a_pulses = 0;
  int          a_base = 0, a_flag_idx = -1;
  logic [3:0]  a_flag_cfg = 4'b0;
  logic [79:0] m_res = '0, a_res = '0;
  logic [79:0] m_cap_a = '0, m_cap_b = '0, a_cap_a = '0, a_cap_b = '0;

  assign mul_done   = (m_cnt == 1) && !m_hang;
  assign mul_result = m_res;
  assign mul_flags  = 4'b0;
  assign add_done   = (a_cnt == 1);
  assign add_result = a_res;
  assign add_flags  = (add_done && (a_pulses - a_base - 1 == a_flag_idx)) ? a_flag_cfg : 4'b0;

  always @(posedge clk) begin
    if (mul_enable) begin
      m_cap_a  <= mul_operand_a;
      m_cap_b  <= mul_operand_b;
      m_res    <= fmul(mul_operand_a, mul_operand_b);
      m_cnt    <= m_lat;
      m_pulses <= m_pulses + 1;
    end else if (m_cnt > 0) begin
      m_cnt <= m_cnt - 1;
    end
    if (add_enable) begin
      a_cap_a  <= add_operand_a;
      a_cap_b  <= add_operand_b;
      a_res    <= fadd(add_operand_a, add_operand_b);
      a_cnt    <= a_lat;
      a_pulses <= a_pulses + 1;
    end else if (a_cnt > 0) begin
      a_cnt <= a_cnt - 1;
    end
  end

  // ---------------- per-cycle compare process ----------------
  logic prev_m = 1'b0, prev_a = 1'b0;
  always @(negedge clk) begin
    if (mul_enable || add_enable)
      chk("enable_single_pulse",
          80'({mul_enable & prev_m, add_enable & prev_a, mul_enable & add_enable}), 80'(0));
    if (busy && mul_done) begin
      chk("mul_opa_stable", mul_operand_a, m_cap_a);
      chk("mul_opb_stable", mul_operand_b, m_cap_b);
    end
    if (busy && add_done) begin
      chk("add_opa_stable", add_operand_a, a_cap_a);
      chk("add_opb_stable", add_operand_b, a_cap_b);
    end
    prev_m <= mul_enable;
    prev_a <= add_enable;
  end

  // ---------------- operation driver + reference model ----------------
  logic [79:0] last_res;
  int          last_lat, last_mul, last_add;
  logic        last_err;
  logic [3:0]  last_stat;

  task automatic run_op(input int poly, input int n, input logic [79:0] x,
                        input int lm, input int la, input bit hang,
                        input int fidx, input logic [3:0] fcfg);
    logic [79:0] e_res;
    int          e_lat, e_mul, e_add, e, mb, ab;
    bit          e_err, shortc, got;
    logic [3:0]  e_stat;
    shortc = 1'b0;
`ifdef FPU_HORNER_ZERO_SHORTCUT_EN
    shortc = (x[78:0] == '0);
`endif
    e_stat = 4'b0;
    e_err  = 1'b0;
    e_mul  = 0;
    e_add  = 0;
    if (n > int'(MAXD)) begin
      e_res = '0; e_err = 1'b1; e_lat = 1;
    end else if (shortc || n == 0) begin
      e_res = rom[poly][0]; e_lat = 1;
    end else if (hang) begin
      e_res = '0; e_err = 1'b1; e_lat = 2 + int'(TMO); e_mul = 1;
    end else begin
      e_res = rom[poly][n];
      for (int i = n - 1; i >= 0; i--) e_res = fadd(fmul(e_res, x), rom[poly][i]);
      e_lat  = 1 + n * (3 + lm + la);
      e_mul  = n;
      e_add  = n;
      e_stat = (fidx >= 0 && fidx < n) ? fcfg : 4'b0;
      e_err  = e_stat[FLAG_INVALID] | e_stat[FLAG_OVERFLOW];
    end

    m_lat = lm; a_lat = la; m_hang = hang;
    a_flag_idx = fidx; a_flag_cfg = fcfg;
    @(negedge clk);
    mb = m_pulses; ab = a_pulses; a_base = a_pulses;
    start = 1'b1; poly_select = SW'(poly); degree = DW'(n); x_in = x;
    @(posedge clk);
    e = 0; got = 1'b0;
    @(negedge clk);
    start = 1'b0;
    while (!got && e < 400) begin
      if (done) got = 1'b1;
      else begin
        @(posedge clk); e++;
        @(negedge clk);
      end
    end
    chk("done_seen", 80'(got), 80'(1));
    last_res = result_out; last_err = error; last_stat = status_flags;
    last_lat = e; last_mul = m_pulses - mb; last_add = a_pulses - ab;
    chk("latency", 80'(e), 80'(e_lat));
    chk("result", result_out, e_res);
    chk("error", 80'(error), 80'(e_err));
    chk("status_flags", 80'(status_flags), 80'(e_stat));
    chk("mul_pulses", 80'(last_mul), 80'(e_mul));
    chk("add_pulses", 80'(last_add), 80'(e_add));
    chk("busy_at_done", 80'(busy), 80'(1));
    @(posedge clk);
    @(negedge clk);
    chk("idle_after_done", 80'({done, busy}), 80'(0));
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_ctrl"}, 80'({busy, done, error, mul_enable, add_enable}), 80'(0));
    chk({tag, "_coeff_sel"}, 80'({coeff_poly, coeff_index}), 80'(0));
    chk({tag, "_status"}, 80'(status_flags), 80'(0));
    chk({tag, "_result"}, result_out, 80'(0));
    chk({tag, "_mul_ops"}, mul_operand_a | mul_operand_b, 80'(0));
    chk({tag, "_add_ops"}, add_operand_a | add_operand_b, 80'(0));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    bit any_done;
    for (int p = 0; p < 16; p++)
      for (int i = 0; i < 16; i++)
        rom[p][i] = r2x(real'(int'($urandom_range(16)) - 8));
    rom[1][0] = 80'h4000_8000_0000_0000_0000;  // 2.0
    rom[1][1] = 80'h4000_C000_0000_0000_0000;  // 3.0
    rom[1][2] = 80'h4001_8000_0000_0000_0000;  // 4.0
    rom[2][0] = 80'h4000_8000_0000_0000_0000;
    rom[3][0] = 80'h4000_8000_0000_0000_0000;

    #2 reset = 1'b1;
    #1 check_all_zero("reset");
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // c=[2,3,4], x=1.0 -> 9.0
    run_op(1, 2, FP_ONE, 2, 2, 1'b0, -1, 4'b0);
    chk("pin_p1_result", last_res, 80'h4002_9000_0000_0000_0000);
    chk("pin_p1_latency", 80'(last_lat), 80'(15));

    // degree 0 returns c0 with no arithmetic
    run_op(2, 0, 80'h4001_C000_0000_0000_0000, 1, 1, 1'b0, -1, 4'b0);
    chk("pin_deg0_result", last_res, 80'h4000_8000_0000_0000_0000);
    chk("pin_deg0_latency", 80'(last_lat), 80'(1));
    chk("pin_deg0_pulses", 80'(last_mul + last_add), 80'(0));

    // degree above MAX_DEGREE
    run_op(0, MAXD + 1, FP_ONE, 1, 1, 1'b0, -1, 4'b0);
    chk("pin_baddeg", 80'({last_err, 7'(last_lat)}), 80'({1'b1, 7'd1}));
    chk("pin_baddeg_result", last_res, 80'(0));

    // x = 0, n = 5
    run_op(3, 5, 80'(0), 1, 1, 1'b0, -1, 4'b0);
    chk("pin_xzero_result", last_res, 80'h4000_8000_0000_0000_0000);
`ifdef FPU_HORNER_ZERO_SHORTCUT_EN
    chk("pin_xzero_latency", 80'(last_lat), 80'(1));
    chk("pin_xzero_pulses", 80'(last_mul + last_add), 80'(0));
`else
    chk("pin_xzero_mul", 80'(last_mul), 80'(5));
    chk("pin_xzero_add", 80'(last_add), 80'(5));
`endif

    // overflow flag on the first add: error, data path unaffected
    run_op(1, 2, FP_ONE, 2, 2, 1'b0, 0, 4'b0010);
    chk("pin_flag_error", 80'(last_err), 80'(1));
    chk("pin_flag_status", 80'(last_stat), 80'(4'b0010));
    chk("pin_flag_result", last_res, 80'h4002_9000_0000_0000_0000);

    // multiplier never completes
    run_op(1, 2, FP_ONE, 2, 2, 1'b1, -1, 4'b0);
    chk("pin_timeout_error", 80'(last_err), 80'(1));
    chk("pin_timeout_result", last_res, 80'(0));
    chk("pin_timeout_latency", 80'(last_lat), 80'(22));
    m_hang = 1'b0;

    // abort while waiting on the adder
    m_lat = 3; a_lat = 3; a_flag_idx = -1;
    @(negedge clk);
    start = 1'b1; poly_select = 4'd1; degree = 4'd2; x_in = FP_ONE;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (!add_enable && k < 100) begin @(negedge clk); k++; end
    chk("abort_reached_add", 80'(add_enable), 80'(1));
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_idle", 80'({busy, done, mul_enable, add_enable}), 80'(0));
    any_done = 1'b0;
    repeat (10) begin @(negedge clk); any_done |= done | busy; end
    chk("abort_no_done", 80'(any_done), 80'(0));

    // reset while waiting on the multiplier
    m_lat = 4;
    @(negedge clk);
    start = 1'b1; poly_select = 4'd0; degree = 4'd3; x_in = FP_ONE;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (!mul_enable && k < 100) begin @(negedge clk); k++; end
    @(negedge clk);
    chk("rst_pre_busy", 80'(busy), 80'(1));
    #2 reset = 1'b1;
    #1 check_all_zero("midrst");
    @(negedge clk);
    reset = 1'b0;
    repeat (8) @(negedge clk);

    // randomized operations
    for (int t = 0; t < 14; t++) begin
      int rp, rn, rlm, rla, rfi;
      logic [3:0] rfc;
      logic [79:0] rx;
      rp  = int'($urandom_range(15));
      rn  = int'($urandom_range(8));
      rlm = 1 + int'($urandom_range(3));
      rla = 1 + int'($urandom_range(3));
      rx  = r2x(real'(int'($urandom_range(12)) - 6) / 2.0);
      rfi = int'($urandom_range(7)) - 1;
      rfc = 4'b0001 << $urandom_range(3);
      run_op(rp, rn, rx, rlm, rla, 1'b0, rfi, rfc);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
